// File: rtl/wide_add_seq.sv
// ---------------------------------------------------------------------------
// wide_add_seq
//
// Computes a WORD_WIDTH-bit add (A+B) or subtract (A-B) by time-sharing a
// single 16-bit carry-lookahead slice adder, least-significant slice first.
// The inter-slice carry is held in a register, so a full-width result takes
// NSLICE cycles after the operands are accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand request
//   in_ready   block can accept operands (high only in IDLE)
//   op_sub     0 = A+B, 1 = A-B (sampled at accept)
//   a, b       operands (sampled at accept)
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   sum        result modulo 2^WORD_WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   busy       high while in RUN or DONE
// ---------------------------------------------------------------------------
module wide_add_seq #(
  parameter int  WORD_WIDTH = 64,
  parameter int  SLICE_W    = 16,
  localparam int NSLICE     = WORD_WIDTH / SLICE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  // Slice index needs at least one bit even when NSLICE = 1.
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 16-bit carry-lookahead adder: 4-bit groups with lookahead across groups,
  // ripple inside each group. Returns {carry_out, sum[15:0]}.
  function automatic logic [16:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        ci);
    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  pg;
    logic [4:0]  gc;
    logic [15:0] c;
    g  = x & y;
    p  = x ^ y;
    gg = 4'd0;
    pg = 4'd0;
    c  = 16'd0;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      pg[i] = &p[4*i +: 4];
    end
    gc[0] = ci;
    gc[1] = gg[0] | (pg[0] & ci);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & ci);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & ci);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & ci);
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 0) begin
        c[i] = gc[i/4];
      end else begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
    end
    return {gc[4], p ^ c};
  endfunction

  state_t                  state_r;
  state_t                  state_s;
  logic                    accept_s;
  logic                    last_s;
  logic [KW-1:0]           k_r;
  logic                    carry_r;
  logic [WORD_WIDTH-1:0]   a_r;
  logic [WORD_WIDTH-1:0]   b_r;
  logic                    op_sub_r;
  logic [WORD_WIDTH-1:0]   b_eff_s;
  logic [SLICE_W-1:0]      a_slice_s;
  logic [SLICE_W-1:0]      b_slice_s;
  logic [SLICE_W:0]        slice_res_s;
  logic                    slice_ovf_s;
  logic [WORD_WIDTH-1:0]   sum_r;
  logic                    cout_r;
  logic                    ovf_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    busy_r;

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s == RUN) || (state_s == DONE);
    end
  end

  // Current slice operands; subtract feeds ~B with carry-in seeded to 1.
  always_comb begin
    last_s      = (k_r == KW'(NSLICE - 1));
    b_eff_s     = op_sub_r ? ~b_r : b_r;
    a_slice_s   = a_r[k_r*SLICE_W +: SLICE_W];
    b_slice_s   = b_eff_s[k_r*SLICE_W +: SLICE_W];
    slice_res_s = cla16(a_slice_s, b_slice_s, carry_r);
    // Only meaningful on the top slice: same-sign inputs, different-sign sum.
    slice_ovf_s = (a_slice_s[SLICE_W-1] == b_slice_s[SLICE_W-1]) &&
                  (slice_res_s[SLICE_W-1] != a_slice_s[SLICE_W-1]);
  end

  // Operand capture, per-slice result write-back and final flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= {WORD_WIDTH{1'b0}};
      b_r      <= {WORD_WIDTH{1'b0}};
      op_sub_r <= 1'b0;
      k_r      <= KW'(0);
      carry_r  <= 1'b0;
      sum_r    <= {WORD_WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r      <= a;
            b_r      <= b;
            op_sub_r <= op_sub;
            k_r      <= KW'(0);
            carry_r  <= op_sub;
          end else begin
            carry_r  <= carry_r;
          end
        end
        RUN: begin
          sum_r[k_r*SLICE_W +: SLICE_W] <= slice_res_s[SLICE_W-1:0];
          carry_r <= slice_res_s[SLICE_W];
          if (last_s) begin
            cout_r <= slice_res_s[SLICE_W];
            ovf_r  <= slice_ovf_s;
          end else begin
            // k stops at the top slice so it never wraps mid-operation.
            k_r    <= k_r + KW'(1);
          end
        end
        DONE: begin
          sum_r <= sum_r;
        end
        default: begin
          k_r <= KW'(0);
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
